div_real_seq: RTL



---
 rtl/div_real_seq.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/div_real_seq.sv
// div_real_seq
// Sequential restoring radix-2 divider for svreal-style fixed-point values.
// Every signal's real value is its signed integer times 2^EXP.
// Computes q = a / b, producing one quotient bit per clock, then
// applies the sign and saturates the result into the quotient format.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   a            dividend, signed, A_WIDTH bits, exponent A_EXP
//   b            divisor, signed, B_WIDTH bits, exponent B_EXP
//   in_valid     a/b valid
//   in_ready     divider idle, can accept a new operation
//   q            quotient, signed, Q_WIDTH bits, exponent Q_EXP
//   div_by_zero  b was zero for this result
//   ovfl         result saturated
//   out_valid    q and flags valid
//   out_ready    downstream accepts the result
module div_real_seq #(
  parameter int A_WIDTH = 16,
  parameter int A_EXP   = -8,
  parameter int B_WIDTH = 17,
  parameter int B_EXP   = -9,
  parameter int Q_WIDTH = 18,
  parameter int Q_EXP   = -10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [A_WIDTH-1:0] a,
  input  logic [B_WIDTH-1:0] b,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [Q_WIDTH-1:0] q,
  output logic               div_by_zero,
  output logic               ovfl,
  output logic               out_valid,
  input  logic               out_ready
);

  // Aligning a's binary point to q's needs a left shift of a by SHIFT bits.
  localparam int SHIFT = A_EXP - B_EXP - Q_EXP;
  localparam int ITER  = A_WIDTH + SHIFT;
  localparam int CNT_W = $clog2(ITER + 1);
  // Common width wide enough for both the raw quotient and the q range limit.
  localparam int CW    = ((ITER > Q_WIDTH) ? ITER : Q_WIDTH) + 1;

  generate
    if (SHIFT < 0) begin : g_bad_shift
      $error("div_real_seq: A_EXP - B_EXP - Q_EXP must be >= 0");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t state, next_state;

  logic               sign;
  logic               div0;
  logic [ITER-1:0]    dividend;
  logic [B_WIDTH-1:0] divisor;
  logic [B_WIDTH-1:0] rem;
  logic [ITER-1:0]    quo;
  logic [CNT_W-1:0]   count;

  logic [A_WIDTH-1:0] abs_a;
  logic [B_WIDTH-1:0] abs_b;
  logic [B_WIDTH:0]   rem_shift;
  logic               take;
  logic [Q_WIDTH-1:0] q_fix;
  logic               ovfl_fix;

  // Magnitudes are unsigned, so the most negative input is represented exactly.
  always_comb begin
    abs_a     = a[A_WIDTH-1] ? (~a + A_WIDTH'(1)) : a;
    abs_b     = b[B_WIDTH-1] ? (~b + B_WIDTH'(1)) : b;
    rem_shift = {rem, dividend[ITER-1]};
    take      = (rem_shift >= {1'b0, divisor});
  end

  // Sign application and saturation of the raw quotient magnitude.
  // A negative magnitude of exactly 2^(Q_WIDTH-1) is representable, so it
  // maps to the minimum value without flagging overflow.
  always_comb begin
    logic [CW-1:0]      quo_ext;
    logic [CW-1:0]      lim;
    logic [Q_WIDTH-1:0] q_max;
    logic [Q_WIDTH-1:0] q_min;
    quo_ext  = CW'(quo);
    lim      = CW'(1) << (Q_WIDTH - 1);
    q_max    = {1'b0, {(Q_WIDTH-1){1'b1}}};
    q_min    = {1'b1, {(Q_WIDTH-1){1'b0}}};
    q_fix    = '0;
    ovfl_fix = 1'b0;
    if (div0) begin
      // b is zero here, so sign is simply the sign of a.
      q_fix    = sign ? q_min : q_max;
      ovfl_fix = 1'b1;
    end else if (!sign) begin
      if (quo_ext >= lim) begin
        q_fix    = q_max;
        ovfl_fix = 1'b1;
      end else begin
        q_fix = Q_WIDTH'(quo_ext);
      end
    end else begin
      if (quo_ext > lim) begin
        q_fix    = q_min;
        ovfl_fix = 1'b1;
      end else begin
        q_fix = Q_WIDTH'(CW'(0) - quo_ext);
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state and handshake outputs. CALC lingers one extra edge after the
  // counter hits zero, giving a fixed ITER+2 edge latency to out_valid.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) next_state = CALC;
      end
      CALC: begin
        if (count == '0) next_state = FIX;
      end
      FIX: begin
        next_state = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath: operand capture, restoring iterations, result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      sign        <= 1'b0;
      div0        <= 1'b0;
      dividend    <= '0;
      divisor     <= '0;
      rem         <= '0;
      quo         <= '0;
      count       <= '0;
      q           <= '0;
      div_by_zero <= 1'b0;
      ovfl        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign     <= a[A_WIDTH-1] ^ b[B_WIDTH-1];
            div0     <= (b == '0);
            dividend <= ITER'(abs_a) << SHIFT;
            divisor  <= abs_b;
            rem      <= '0;
            quo      <= '0;
            count    <= CNT_W'(ITER);
          end
        end
        CALC: begin
          if (count != '0) begin
            dividend <= dividend << 1;
            if (take) begin
              rem <= B_WIDTH'(rem_shift - {1'b0, divisor});
              quo <= {quo[ITER-2:0], 1'b1};
            end else begin
              rem <= rem_shift[B_WIDTH-1:0];
              quo <= {quo[ITER-2:0], 1'b0};
            end
            count <= count - CNT_W'(1);
          end
        end
        FIX: begin
          q           <= q_fix;
          ovfl        <= ovfl_fix;
          div_by_zero <= div0;
        end
        default: ;
      endcase
    end
  end

endmodule
